// File: rtl/rr_mux_pkg.sv
// Shared definitions for the round-robin mux arbiter: FSM encoding and a
// constant-evaluable ceil(log2) helper used to size the beat counter.
package rr_mux_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // ceil(log2(v)); returns 0 for v <= 1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// Bus between the arbiter and its requesters/downstream consumer.
// Handshake: a beat transfers on every cycle where VALID and READY are both
// high; VALID never waits on READY, and Y is only meaningful while VALID=1.
interface rr_mux_arbiter_if #(
    parameter int S = 4,
    parameter int M = 1
);
    localparam int N = 2 ** S;

    logic [N-1:0]   REQ;
    logic [M*N-1:0] A;
    logic           READY;
    logic [N-1:0]   GNT;
    logic [S-1:0]   SEL;
    logic           EN;
    logic           VALID;
    logic [M-1:0]   Y;

    // Arbiter side.
    modport master (
        input  REQ, A, READY,
        output GNT, SEL, EN, VALID, Y
    );

    // Requesters and downstream consumer side.
    modport slave (
        output REQ, A, READY,
        input  GNT, SEL, EN, VALID, Y
    );
endinterface

// File: rtl/rr_mux_arbiter_mux.sv
// EN-gated combinational M-bit, 2**S-input multiplexer.
module mux_s_sel_m_bits #(
    parameter int S = 4,
    parameter int M = 1
) (
    input  logic                  en_i,
    input  logic [S-1:0]          sel_i,
    input  logic [M*(2**S)-1:0]   a_i,
    output logic [M-1:0]          y_o
);
    // Output is forced to zero whenever the mux is not enabled.
    always_comb begin
        y_o = '0;
        if (en_i) begin
            y_o = a_i[sel_i*M +: M];
        end
    end
endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one EN-gated mux between 2**S requesters.
// A grant lasts up to MAX_BURST transferred beats or until the granted
// requester withdraws, followed by one IDLE bubble before re-arbitration.
module rr_mux_arbiter
    import rr_mux_pkg::*;
#(
    parameter int S         = 4,
    parameter int M         = 1,
    parameter int MAX_BURST = 4,
    localparam int CW       = clog2(MAX_BURST) + 1
) (
    input  logic              CLK,
    input  logic              RST,
    rr_mux_arbiter_if.master  bus,
    output state_t            dbg_state_o,
    output logic [S-1:0]      dbg_ptr_o,
    output logic [CW-1:0]     dbg_cnt_o
);
    localparam int N = 2 ** S;

    state_t         state_q, state_d;
    logic [S-1:0]   ptr_q, ptr_d;
    logic [S-1:0]   sel_q, sel_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           valid;
    logic           xfer;

    // First set bit of req searching ptr, ptr+1, ... with wrap-around.
    function automatic logic [S-1:0] rr_pick(input logic [N-1:0] req,
                                             input logic [S-1:0] ptr);
        logic [S-1:0] idx;
        logic [S-1:0] pick;
        logic         found;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = ptr + S'(i);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign valid = (state_q == ST_BUSY) && bus.REQ[sel_q];
    assign xfer  = valid && bus.READY;

    // Next-state: arbitrate in IDLE, count beats and release in BUSY.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|bus.REQ) begin
                    sel_d        = rr_pick(bus.REQ, ptr_q);
                    gnt_d        = '0;
                    gnt_d[sel_d] = 1'b1;
                    cnt_d        = '0;
                    state_d      = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (xfer) begin
                    cnt_d = cnt_q + CW'(1);
                end
                // Final beat and withdrawal in the same cycle release once.
                if ((xfer && (cnt_q == CW'(MAX_BURST - 1))) || !bus.REQ[sel_q]) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    cnt_d   = '0;
                    ptr_d   = sel_q + S'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register; reset overrides everything, including a pending beat.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            gnt_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.GNT   = gnt_q;
    assign bus.SEL   = sel_q;
    assign bus.EN    = (state_q == ST_BUSY);
    assign bus.VALID = valid;

    mux_s_sel_m_bits #(
        .S(S),
        .M(M)
    ) u_mux (
        .en_i (bus.EN),
        .sel_i(sel_q),
        .a_i  (bus.A),
        .y_o  (bus.Y)
    );

    assign dbg_state_o = state_q;
    assign dbg_ptr_o   = ptr_q;
    assign dbg_cnt_o   = cnt_q;
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: S=4, M=2 instance with MAX_BURST=4 and
// a second MAX_BURST=1 instance for the wrap-around grant sequence.
module tb_rr_mux_arbiter;
    import rr_mux_pkg::*;

    logic CLK;
    logic RST;

    rr_mux_arbiter_if #(.S(4), .M(2)) bus ();
    rr_mux_arbiter_if #(.S(4), .M(2)) bus1 ();

    state_t      dbg_state, dbg_state1;
    logic [3:0]  dbg_ptr, dbg_ptr1;
    logic [2:0]  dbg_cnt;
    logic [0:0]  dbg_cnt1;

    int n_checks = 0;
    int n_pass   = 0;
    int beat_cnt = 0;

    // Expected beats, packed as {SEL, Y}.
    logic [5:0] exp_q[$];

    rr_mux_arbiter #(.S(4), .M(2), .MAX_BURST(4)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .bus        (bus),
        .dbg_state_o(dbg_state),
        .dbg_ptr_o  (dbg_ptr),
        .dbg_cnt_o  (dbg_cnt)
    );

    rr_mux_arbiter #(.S(4), .M(2), .MAX_BURST(1)) dut1 (
        .CLK        (CLK),
        .RST        (RST),
        .bus        (bus1),
        .dbg_state_o(dbg_state1),
        .dbg_ptr_o  (dbg_ptr1),
        .dbg_cnt_o  (dbg_cnt1)
    );

    // ---------------- clock / reset ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        bus.REQ    = '0;
        bus.A      = '0;
        bus.READY  = 1'b0;
        bus1.REQ   = '0;
        bus1.A     = '0;
        bus1.READY = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        idle_inputs();
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic push_beats(input logic [3:0] sel, input logic [1:0] y, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({sel, y});
    endtask

    // ---------------- scoreboard monitor ----------------
    // Samples mid-cycle: a beat seen here completes on the next rising edge.
    always @(negedge CLK) begin
        if (!RST && bus.VALID && bus.READY) begin
            beat_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_beat", {26'd0, bus.SEL, bus.Y}, 32'hFFFF_FFFF);
            end else begin
                check("beat", {26'd0, bus.SEL, bus.Y}, {26'd0, exp_q.pop_front()});
            end
        end
    end

    // ---------------- directed stimulus ----------------
    logic [15:0] g_exp [8];
    int          beats0;

    initial begin
        g_exp = '{16'h0001, 16'h0000, 16'h8000, 16'h0000,
                  16'h0001, 16'h0000, 16'h8000, 16'h0000};
        idle_inputs();

        // 1: reset with every requester asking
        RST     = 1'b1;
        bus.REQ = 16'hFFFF;
        tick();
        tick();
        check("rst_gnt",   {16'd0, bus.GNT}, 32'h0);
        check("rst_en",    {31'd0, bus.EN}, 32'h0);
        check("rst_valid", {31'd0, bus.VALID}, 32'h0);
        check("rst_y",     {30'd0, bus.Y}, 32'h0);
        check("rst_ptr",   {28'd0, dbg_ptr}, 32'h0);
        RST = 1'b0;
        tick();
        check("first_gnt", {16'd0, bus.GNT}, 32'h0001);
        check("first_sel", {28'd0, bus.SEL}, 32'h0);
        do_reset();

        // 2: single requester 5, full burst, bubble, re-grant
        bus.REQ   = 16'h0020;
        bus.A     = '0;
        bus.A[10 +: 2] = 2'b10;
        bus.READY = 1'b1;
        push_beats(4'd5, 2'b10, 4);
        tick();
        check("t2_gnt", {16'd0, bus.GNT}, 32'h0020);
        check("t2_sel", {28'd0, bus.SEL}, 32'd5);
        check("t2_y",   {30'd0, bus.Y}, 32'h2);
        tick(); tick(); tick();
        check("t2_last_cnt", {29'd0, dbg_cnt}, 32'd3);
        tick();
        check("t2_bubble_en",  {31'd0, bus.EN}, 32'h0);
        check("t2_bubble_gnt", {16'd0, bus.GNT}, 32'h0);
        check("t2_ptr",        {28'd0, dbg_ptr}, 32'd6);
        tick();
        check("t2_regnt", {16'd0, bus.GNT}, 32'h0020);
        bus.REQ = '0;
        tick();
        check("t2_release", {16'd0, bus.GNT}, 32'h0);
        do_reset();

        // 3: MAX_BURST=1 instance, requesters 0 and 15 alternate
        bus1.REQ   = 16'h8001;
        bus1.READY = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("t3_gnt%0d", i), {16'd0, bus1.GNT}, {16'd0, g_exp[i]});
        end
        bus1.REQ = '0;
        do_reset();

        // 4: backpressure on requester 3
        bus.REQ  = 16'h0008;
        bus.A    = '0;
        bus.A[6 +: 2] = 2'b01;
        tick();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t4_valid%0d", i), {31'd0, bus.VALID}, 32'h1);
            check($sformatf("t4_cnt%0d", i),   {29'd0, dbg_cnt}, 32'h0);
            tick();
        end
        beats0    = beat_cnt;
        bus.READY = 1'b1;
        push_beats(4'd3, 2'b01, 4);
        tick(); tick(); tick(); tick();
        check("t4_beats", beat_cnt - beats0, 32'd4);
        check("t4_gnt_off", {16'd0, bus.GNT}, 32'h0);
        check("t4_ptr", {28'd0, dbg_ptr}, 32'd4);
        do_reset();

        // 5: requester 7 withdraws after 2 of 4 beats
        bus.REQ   = 16'h0080;
        bus.A     = '0;
        bus.A[14 +: 2] = 2'b11;
        bus.READY = 1'b1;
        push_beats(4'd7, 2'b11, 2);
        tick(); tick(); tick();
        check("t5_cnt", {29'd0, dbg_cnt}, 32'd2);
        bus.REQ = '0;
        #1;
        check("t5_valid_drop", {31'd0, bus.VALID}, 32'h0);
        tick();
        check("t5_gnt", {16'd0, bus.GNT}, 32'h0);
        check("t5_ptr", {28'd0, dbg_ptr}, 32'd8);
        do_reset();

        // 6: reset during beat 2 of a grant to requester 9
        bus.REQ   = 16'h0200;
        bus.A     = '0;
        bus.A[18 +: 2] = 2'b01;
        bus.READY = 1'b1;
        push_beats(4'd9, 2'b01, 1);
        tick();
        check("t6_sel", {28'd0, bus.SEL}, 32'd9);
        tick();
        RST = 1'b1;
        tick();
        check("t6_gnt", {16'd0, bus.GNT}, 32'h0);
        check("t6_sel_rst", {28'd0, bus.SEL}, 32'h0);
        check("t6_ptr", {28'd0, dbg_ptr}, 32'h0);
        check("t6_state", {31'd0, dbg_state}, {31'd0, ST_IDLE});
        RST = 1'b0;
        idle_inputs();
        tick();
        tick();

        // ---------------- final report ----------------
        check("beats_left", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
